// File: rtl/gamma_corr_pkg.sv
// gamma_corr_pkg: power-up contents of the gamma LUT used by gamma_sched.
// The table is a square-law curve (gamma 2.0) for 8-bit channels, scaled so
// that 0 maps to 0 and full scale maps to full scale: c[x] = (x*x) / 255.

package gamma_corr_pkg;

    localparam int gamma_corr_width_c = 8;
    localparam int gamma_corr_depth_c = 256;

    typedef logic [gamma_corr_depth_c-1:0][gamma_corr_width_c-1:0] gamma_tbl_t;

    // Build the correction table at elaboration time.
    function automatic gamma_tbl_t gamma_corr_build_f();
        gamma_tbl_t                    tbl;
        logic [gamma_corr_width_c-1:0] idx_v;
        for (int i = 32'sd0; i < gamma_corr_depth_c; i++) begin
            idx_v      = i[gamma_corr_width_c-1:0];
            tbl[idx_v] = gamma_corr_width_c'((i * i) / (gamma_corr_depth_c - 32'sd1));
        end
        return tbl;
    endfunction

    localparam gamma_tbl_t gamma_corr_c = gamma_corr_build_f();

endpackage

// File: rtl/gamma_sched.sv
// gamma_sched: gamma-corrects R, G, B through one synchronous-read LUT that is
// time-shared between the three channel reads and configuration writes.
// One pixel is in flight at a time: IDLE/OUT accept, RD_R..CAP read the LUT.
// Optional macro GAMMA_LUT_WR_EN: runtime LUT writes over cfg_wr/cfg_addr/
// cfg_data with a one-cycle cfg_ack. Without it the LUT is the read-only
// gamma_corr_c table, cfg_* are ignored and cfg_ack is tied low.
// gamma_corr_c is built for 8-bit channels, so pixel_width_p must stay 8
// unless the package table is regenerated for another width.

module gamma_sched
    import gamma_corr_pkg::*;
#(
    parameter int pixel_width_p = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [pixel_width_p-1:0] in_r,
    input  logic [pixel_width_p-1:0] in_g,
    input  logic [pixel_width_p-1:0] in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [pixel_width_p-1:0] out_r,
    output logic [pixel_width_p-1:0] out_g,
    output logic [pixel_width_p-1:0] out_b,
    input  logic                     cfg_wr,
    input  logic [pixel_width_p-1:0] cfg_addr,
    input  logic [pixel_width_p-1:0] cfg_data,
    output logic                     cfg_ack
);

    localparam int lut_depth_c = 2 ** pixel_width_p;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_R = 3'd1,
        RD_G = 3'd2,
        RD_B = 3'd3,
        CAP  = 3'd4,
        OUT  = 3'd5
    } state_t;

    state_t                     state_r;
    state_t                     state_nxt_s;
    logic                       run_r;        // low from reset until the first edge after release
    logic                       wr_req_s;     // a not-yet-served LUT write is pending
    logic                       in_ready_s;
    logic                       accept_s;
    logic                       lut_we_s;
    logic [pixel_width_p-1:0]   lut_addr_s;
    logic [pixel_width_p-1:0]   lut_rd_r;
    logic [pixel_width_p-1:0]   pix_red_r;
    logic [pixel_width_p-1:0]   pix_green_r;
    logic [pixel_width_p-1:0]   pix_blue_r;
    logic [pixel_width_p-1:0]   red_r;
    logic [pixel_width_p-1:0]   green_r;
    logic [pixel_width_p-1:0]   blue_r;

`ifdef GAMMA_LUT_WR_EN
    logic cfg_ack_r;

    // During the ack cycle cfg_wr may still show the old request, so it is
    // only a new write once the ack has gone by.
    assign wr_req_s = cfg_wr & ~cfg_ack_r;
    assign cfg_ack  = cfg_ack_r;
`else
    logic unused_cfg_s;

    assign wr_req_s     = 1'b0;
    assign cfg_ack      = 1'b0;
    assign unused_cfg_s = ^{cfg_wr, cfg_addr, cfg_data};
`endif

    assign in_ready  = in_ready_s;
    assign accept_s  = in_valid & in_ready_s;
    assign out_valid = (state_r == OUT);
    assign out_r     = red_r;
    assign out_g     = green_r;
    assign out_b     = blue_r;

    // Next-state, handshake and LUT port arbitration.
    always_comb begin
        state_nxt_s = state_r;
        in_ready_s  = 1'b0;
        lut_we_s    = 1'b0;
        lut_addr_s  = pix_red_r;
        case (state_r)
            IDLE: begin
`ifdef GAMMA_LUT_WR_EN
                lut_addr_s = cfg_addr;
`endif
                if (!run_r) begin
                    state_nxt_s = IDLE;
                end else if (wr_req_s) begin
                    lut_we_s = 1'b1;
                end else begin
                    in_ready_s = 1'b1;
                    if (in_valid) begin
                        state_nxt_s = RD_R;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
            end
            RD_R: begin
                lut_addr_s  = pix_red_r;
                state_nxt_s = RD_G;
            end
            RD_G: begin
                lut_addr_s  = pix_green_r;
                state_nxt_s = RD_B;
            end
            RD_B: begin
                lut_addr_s  = pix_blue_r;
                state_nxt_s = CAP;
            end
            CAP: begin
                state_nxt_s = OUT;
            end
            OUT: begin
                if (!out_ready) begin
                    state_nxt_s = OUT;
                end else if (!wr_req_s) begin
                    in_ready_s = 1'b1;
                    if (in_valid) begin
                        state_nxt_s = RD_R;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register and run flag; reset discards any pixel in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            run_r   <= 1'b1;
        end
    end

    // Register the raw channels at acceptance so they stay fixed during the reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_red_r   <= {pixel_width_p{1'b0}};
            pix_green_r <= {pixel_width_p{1'b0}};
            pix_blue_r  <= {pixel_width_p{1'b0}};
        end else if (accept_s) begin
            pix_red_r   <= in_r;
            pix_green_r <= in_g;
            pix_blue_r  <= in_b;
        end
    end

    // Capture each LUT read one cycle after its address was presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_r   <= {pixel_width_p{1'b0}};
            green_r <= {pixel_width_p{1'b0}};
            blue_r  <= {pixel_width_p{1'b0}};
        end else begin
            case (state_r)
                RD_G:    red_r   <= lut_rd_r;
                RD_B:    green_r <= lut_rd_r;
                CAP:     blue_r  <= lut_rd_r;
                default: red_r   <= red_r;
            endcase
        end
    end

`ifdef GAMMA_LUT_WR_EN
    // Writable LUT: power-up contents from gamma_corr_c, never touched by reset.
    logic [lut_depth_c-1:0][pixel_width_p-1:0] lut_mem_r = gamma_corr_c;

    // LUT write port; writes are only granted in IDLE, never mid-pixel.
    always_ff @(posedge clk) begin
        if (lut_we_s) begin
            lut_mem_r[lut_addr_s] <= cfg_data;
        end
    end

    // Synchronous LUT read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_rd_r <= {pixel_width_p{1'b0}};
        end else begin
            lut_rd_r <= lut_mem_r[lut_addr_s];
        end
    end

    // One-cycle acknowledge following each performed write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ack_r <= 1'b0;
        end else begin
            cfg_ack_r <= lut_we_s;
        end
    end
`else
    // Synchronous read of the fixed correction table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_rd_r <= {pixel_width_p{1'b0}};
        end else begin
            lut_rd_r <= gamma_corr_c[lut_addr_s];
        end
    end
`endif

endmodule

// File: tb/tb_gamma_sched.sv
// tb_gamma_sched: directed vectors for gamma_sched with a scoreboard queue.
// Expected values are hand-computed from c[x] = (x*x)/255, e.g.
// 00->00 10->01 30->09 40->10 60->24 80->40 C0->90 E0->C4 FF->FF 01->00.

module tb_gamma_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_r, in_g, in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_r, out_g, out_b;
    logic       cfg_wr;
    logic [7:0] cfg_addr, cfg_data;
    logic       cfg_ack;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         acc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ack_cnt = 0;
    int   last_acc = 0;
    int   last_xfer = 0;
    logic prev_ov = 1'b0;
`ifdef GAMMA_LUT_WR_EN
    int   ack_cyc = 0;
    localparam logic [7:0] exp10_c = 8'hAA;
`else
    localparam logic [7:0] exp10_c = 8'h01;
`endif

    gamma_sched #(.pixel_width_p(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ack(cfg_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Offer one pixel until accepted; push its expected result at acceptance.
    task automatic send_pixel(input logic [7:0] r, g, b, er, eg, eb);
        int   n = 0;
        logic acc = 1'b0;
        logic done = 1'b0;
        in_r = r; in_g = g; in_b = b; in_valid = 1'b1;
        while (!done && n < 60) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (acc) done = 1'b1;
        end
        in_valid = 1'b0;
        if (done) begin
            last_acc = cyc;
            exp_q.push_back('{r: er, g: eg, b: eb, acc: cyc});
        end else begin
            check("accept_timeout", 0, 1);
        end
    endtask

`ifdef GAMMA_LUT_WR_EN
    // Hold cfg_wr until cfg_ack is seen, then drop it.
    task automatic cfg_write(input logic [7:0] a, d);
        int n = 0;
        cfg_addr = a; cfg_data = d; cfg_wr = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!cfg_ack && n < 20);
        check("cfg_ack_seen", int'(cfg_ack), 1);
        ack_cyc = cyc;
        cfg_wr = 1'b0;
    endtask
`endif

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented output against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (cfg_ack) ack_cnt++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    if (!prev_ov) check("latency", cyc, exp_q[0].acc + 4);
                    check("out_r", int'(out_r), int'(exp_q[0].r));
                    check("out_g", int'(out_g), int'(exp_q[0].g));
                    check("out_b", int'(out_b), int'(exp_q[0].b));
                    if (!out_ready) begin
                        check("in_ready_stall", int'(in_ready), 0);
                    end else begin
                        last_xfer = cyc + 1;
                        exp_q.delete(0);
                    end
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        int a0;
        int n;
        rst_n = 1'b0; in_valid = 1'b0; in_r = 8'h00; in_g = 8'h00; in_b = 8'h00;
        out_ready = 1'b1; cfg_wr = 1'b0; cfg_addr = 8'h00; cfg_data = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_cfg_ack", int'(cfg_ack), 0);
        check("rst_out_rgb", int'({out_r, out_g, out_b}), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_before_edge", int'(in_ready), 0);
        @(negedge clk);
        check("in_ready_after_edge", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Basic pixel, extremes and mid-scale
        send_pixel(8'h00, 8'h80, 8'hFF, 8'h00, 8'h40, 8'hFF);
        wait_drain();

`ifdef GAMMA_LUT_WR_EN
        // LUT write then a pixel that reads the new entry on every channel
        a0 = ack_cnt;
        cfg_write(8'h10, 8'hAA);
        repeat (2) @(posedge clk);
        #1;
        check("ack_pulses", ack_cnt - a0, 1);
        send_pixel(8'h10, 8'h10, 8'h10, 8'hAA, 8'hAA, 8'hAA);
        wait_drain();

        // Write and pixel together: write first, pixel in the ack cycle
        fork
            cfg_write(8'h20, 8'h55);
            send_pixel(8'h20, 8'h20, 8'h20, 8'h55, 8'h55, 8'h55);
        join
        check("accept_after_write", last_acc, ack_cyc + 1);
        wait_drain();
`else
        // cfg_* ignored: no ack, table unchanged, pixel not blocked
        a0 = ack_cnt;
        fork
            begin
                cfg_addr = 8'h10; cfg_data = 8'hAA; cfg_wr = 1'b1;
                repeat (8) @(posedge clk);
                #1 cfg_wr = 1'b0;
            end
            send_pixel(8'h10, 8'h10, 8'h10, 8'h01, 8'h01, 8'h01);
        join
        check("ack_pulses", ack_cnt - a0, 0);
        wait_drain();
        send_pixel(8'h40, 8'h30, 8'hC0, 8'h10, 8'h09, 8'h90);
        wait_drain();
`endif

        // Output stall with the next pixel waiting, then back-to-back accept
        out_ready = 1'b0;
        fork
            begin
                send_pixel(8'hC0, 8'h60, 8'hE0, 8'h90, 8'h24, 8'hC4);
                send_pixel(8'h40, 8'h30, 8'h01, 8'h10, 8'h09, 8'h00);
            end
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!out_valid && n < 60);
                if (!out_valid) check("stall_out_valid_timeout", 0, 1);
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        check("back_to_back", last_acc, last_xfer);
        wait_drain();

        // Reset while the pixel is in RD_G; outputs clear at once
        send_pixel(8'h10, 8'h10, 8'h10, exp10_c, exp10_c, exp10_c);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_r", int'(out_r), 0);
        check("midrst_out_g", int'(out_g), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LUT contents survive reset
        send_pixel(8'h10, 8'h10, 8'h10, exp10_c, exp10_c, exp10_c);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
